data_mem_initiator: RTL and testbench

- Initiator-side controller that drives the DATA_MEMORY port (address, write data, write enable, read data) on behalf of the MIPS load/store stage.
- Accepts one byte, halfword or word load/store request at a time.
- Sub-word stores run as read-modify-write against the word-wide memory.
- Loads return extracted, sign- or zero-extended data.
- Misaligned and out-of-range accesses are flagged without touching memory.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_lane_ops.sv | 45 ++++
 rtl/data_mem_initiator.sv | 120 ++++++++++++
 tb/tb_data_mem_initiator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states
// and the memory word width.
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane_ops.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into a word read from memory.
module mem_lane_ops
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [WORD_W-1:0] o_ext,
  output logic [WORD_W-1:0] o_merged
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {i_addr_lo, 3'b000};
  assign w_half_sh = {i_addr_lo[1], 4'b0000};
  assign w_byte    = 8'(i_word >> w_byte_sh);
  assign w_half    = 16'(i_word >> w_half_sh);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_ext    = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_ext    = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
        o_merged = (i_word & ~(32'h0000_00FF << w_byte_sh))
                 | (32'(i_wdata[7:0]) << w_byte_sh);
      end
      SZ_HALF: begin
        o_ext    = i_signed ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        o_merged = (i_word & ~(32'h0000_FFFF << w_half_sh))
                 | (32'(i_wdata[15:0]) << w_half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_initiator.sv
// Drives a word-wide data memory for one byte/half/word load or store at a
// time; sub-word stores run as read-modify-write.
module data_mem_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(MEM_BYTES);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rd_word;
  logic                r_err;
  logic [WORD_W-1:0]   r_rdata;

  logic                w_accept;
  logic                w_err;
  logic [WORD_W-1:0]   w_lane_word;
  logic [WORD_W-1:0]   w_ext;
  logic [WORD_W-1:0]   w_merged;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;

  assign w_err = (req_size == 2'b11)
              || ((req_size == SZ_HALF) && req_addr[0])
              || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
              || (req_addr >= LP_LIMIT);

  // Extraction sees live read data in RD; the merge uses the word captured then.
  assign w_lane_word = (r_state == ST_WR) ? r_rd_word : mem_rd;

  mem_lane_ops u_lane_ops (
    .i_word    (w_lane_word),
    .i_wdata   (r_wdata),
    .i_addr_lo (r_addr[1:0]),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .o_ext     (w_ext),
    .o_merged  (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid)
                 w_next = w_err ? ST_RESP
                        : ((req_we && req_size == SZ_WORD) ? ST_WR : ST_RD);
      ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_size    <= SZ_BYTE;
      r_signed  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_word <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        if (w_err) r_rdata <= '0;
      end
      if (r_state == ST_RD) begin
        r_rd_word <= mem_rd;
        if (!r_we) r_rdata <= w_ext;
      end
      if (r_state == ST_WR) r_rdata <= '0;
    end
  end

  assign resp_valid = (r_state == ST_RESP);
  assign resp_err   = (r_state == ST_RESP) & r_err;
  assign resp_rdata = r_rdata;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wd     = (r_state == ST_WR) ? w_merged : '0;
  // Gated by rst so a reset landing on a WR cycle never commits the write.
  assign mem_we     = (r_state == ST_WR) & ~rst;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Scoreboard bench for data_mem_initiator with a 256-byte behavioural memory.
module tb_data_mem_initiator;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:63];
  exp_t        exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          resp_prev = 0;
  int          resp_last = 0;

  always #5 clk = ~clk;

  data_mem_initiator #(.ADDR_W(32), .MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always_comb mem_rd = (mem_addr < 32'd256) ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_prev = resp_last;
      resp_last = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic push(input logic err, input logic [31:0] rdata);
    exp_t e;
    e = {err, rdata};
    exp_q.push_back(e);
  endtask

  task automatic run_op(input string name, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input logic exp_we);
    logic saw_we;
    int   lat;
    saw_we = 1'b0;
    lat = 0;
    push(exp_err, exp_rdata);
    start(we, size, sgn, addr, wdata);
    for (int i = 1; i <= 8; i++) begin
      saw_we |= mem_we;
      if (resp_valid) begin
        lat = i;
        break;
      end
      next_cycle();
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_mem_we"}, {31'b0, saw_we}, {31'b0, exp_we});
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899_AABB;
    mem[5]  = 32'h0123_4567;
    mem[63] = 32'h7F12_3456;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);

    // Word store with cycle-level detail.
    push(1'b0, 32'h0);
    start(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_c1_mem_we", {31'b0, mem_we}, 32'h1);
    check("sw_c1_mem_addr", mem_addr, 32'h10);
    check("sw_c1_mem_wd", mem_wd, 32'hDEAD_BEEF);
    next_cycle();
    check("sw_c2_resp_valid", {31'b0, resp_valid}, 32'h1);
    next_cycle();
    check("sw_mem_word", mem[4], 32'hDEAD_BEEF);
    run_op("lw_readback", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);
    mem[4] = 32'h8899_AABB;

    // Loads: lanes and extension.
    run_op("lb_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF88, 2, 1'b0);
    run_op("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0000_0088, 2, 1'b0);
    run_op("lhu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_AABB, 2, 1'b0);
    run_op("lh_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_8899, 2, 1'b0);
    run_op("lb_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAA, 2, 1'b0);
    run_op("lb_ff", 1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 1'b0, 32'h0000_007F, 2, 1'b0);

    // Half store read-modify-write.
    push(1'b0, 32'h0);
    start(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
    check("sh_c1_mem_we", {31'b0, mem_we}, 32'h0);
    check("sh_c1_mem_addr", mem_addr, 32'h10);
    next_cycle();
    check("sh_c2_mem_we", {31'b0, mem_we}, 32'h1);
    check("sh_c2_mem_wd", mem_wd, 32'h1234_AABB);
    next_cycle();
    check("sh_c3_resp_valid", {31'b0, resp_valid}, 32'h1);
    next_cycle();
    check("sh_mem_word", mem[4], 32'h1234_AABB);
    mem[4] = 32'h8899_AABB;

    run_op("sb_13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_005A, 1'b0, 32'h0, 3, 1'b1);
    check("sb_mem_word", mem[4], 32'h5A99_AABB);
    mem[4] = 32'h8899_AABB;

    // Errors: immediate response, memory untouched.
    run_op("err_lh_11", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    run_op("err_lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    run_op("err_size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    run_op("err_sw_12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFE_F00D, 1'b1, 32'h0, 1, 1'b0);
    check("err_mem_word", mem[4], 32'h8899_AABB);

    // Back-to-back word loads with req_valid held high.
    push(1'b0, 32'h8899_AABB);
    push(1'b0, 32'h0123_4567);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_valid = 1'b1;
    next_cycle();
    req_addr = 32'h14;
    check("b2b_c1_ready", {31'b0, req_ready}, 32'h0);
    next_cycle();
    check("b2b_c2_ready", {31'b0, req_ready}, 32'h0);
    check("b2b_c2_resp", {31'b0, resp_valid}, 32'h1);
    next_cycle();
    check("b2b_c3_ready", {31'b0, req_ready}, 32'h1);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    check("b2b_c5_resp", {31'b0, resp_valid}, 32'h1);
    next_cycle();
    check("b2b_spacing", 32'(resp_last - resp_prev), 32'd3);

    // Reset during the write cycle of a byte RMW.
    start(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0055);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rstmid_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstmid_ready", {31'b0, req_ready}, 32'h1);
    check("rstmid_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rstmid_resp_rdata", resp_rdata, 32'h0);
    next_cycle();
    check("rstmid_resp_valid2", {31'b0, resp_valid}, 32'h0);
    check("rstmid_mem_word", mem[4], 32'h8899_AABB);

    repeat (2) next_cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
